// File: rtl/mmio_io_ctrl_pkg.sv
// Shared definitions for the memory-mapped I/O controller.
// Holds the default register map, control/status bit positions, the
// register-select encoding used by the bus decoder and a helper that
// assembles a control/status word.
package mmio_io_ctrl_pkg;

    localparam logic [31:0] ADDR_HEX_DEF   = 32'hF000_0000;
    localparam logic [31:0] ADDR_LEDR_DEF  = 32'hF000_0004;
    localparam logic [31:0] ADDR_KEY_DEF   = 32'hF000_0010;
    localparam logic [31:0] ADDR_SW_DEF    = 32'hF000_0014;
    localparam logic [31:0] ADDR_KCTRL_DEF = 32'hF000_0110;
    localparam logic [31:0] ADDR_SCTRL_DEF = 32'hF000_0114;

    localparam int CTRL_READY_BIT   = 0;
    localparam int CTRL_OVERRUN_BIT = 2;
    localparam int CTRL_IE_BIT      = 8;

    typedef enum logic [2:0] {
        SEL_NONE  = 3'd0,
        SEL_HEX   = 3'd1,
        SEL_LEDR  = 3'd2,
        SEL_KEY   = 3'd3,
        SEL_SW    = 3'd4,
        SEL_KCTRL = 3'd5,
        SEL_SCTRL = 3'd6
    } reg_sel_e;

    // Control/status word: READY, OVERRUN and IE in place, all other bits zero.
    function automatic logic [31:0] ctrl_word(input logic ready,
                                              input logic overrun,
                                              input logic ie);
        logic [31:0] w;
        w                   = 32'h0000_0000;
        w[CTRL_READY_BIT]   = ready;
        w[CTRL_OVERRUN_BIT] = overrun;
        w[CTRL_IE_BIT]      = ie;
        return w;
    endfunction

endpackage

// File: rtl/mmio_io_ctrl_if.sv
// Data-memory-side bus between the processor and the I/O controller.
//   addr/wr_en/rd_en/wr_data : driven by the processor (master)
//   rd_data/io_hit           : driven by the controller (slave), combinational
interface mmio_io_ctrl_if #(
    parameter int DBITS = 32
) ();

    logic [DBITS-1:0] addr;
    logic             wr_en;
    logic             rd_en;
    logic [DBITS-1:0] wr_data;
    logic [DBITS-1:0] rd_data;
    logic             io_hit;

    modport master (
        output addr, wr_en, rd_en, wr_data,
        input  rd_data, io_hit
    );

    modport slave (
        input  addr, wr_en, rd_en, wr_data,
        output rd_data, io_hit
    );

endinterface

// File: rtl/mmio_io_ctrl_input_debouncer.sv
// Two-flop synchroniser followed by an independent debounce counter per bit.
//   clk, reset_n : clock, asynchronous active-low reset
//   din          : raw asynchronous inputs (already polarity-corrected)
//   dout         : debounced vector (registered)
//   change       : high in the cycle at whose end any dout bit flips
// A bit's counter runs while the synchronised value differs from the
// debounced value; once it has sat at DEBOUNCE_CYCLES-1 the debounced bit
// takes the new value, giving 2 + DEBOUNCE_CYCLES cycles from a stable edge.
module input_debouncer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             change
);

    localparam int            CW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] deb_r;
    logic [WIDTH-1:0] flip_s;
    logic [CW-1:0]    cnt_r [WIDTH];

    // Bits whose debounced value flips on the coming edge.
    always_comb begin
        flip_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if ((sync2_r[i] != deb_r[i]) && (cnt_r[i] == CNT_LAST)) begin
                flip_s[i] = 1'b1;
            end else begin
                flip_s[i] = 1'b0;
            end
        end
    end

    // Two-stage metastability synchroniser.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= {WIDTH{1'b0}};
            sync2_r <= {WIDTH{1'b0}};
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
        end
    end

    // Per-bit stability counters and debounced values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_r <= {WIDTH{1'b0}};
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= {CW{1'b0}};
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    cnt_r[i] <= {CW{1'b0}};
                end else if (flip_s[i]) begin
                    cnt_r[i] <= {CW{1'b0}};
                    deb_r[i] <= sync2_r[i];
                end else begin
                    cnt_r[i] <= cnt_r[i] + {{(CW-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign dout   = deb_r;
    // Decoded straight from registered state so status can be set on the
    // same edge the debounced value changes.
    assign change = |flip_s;

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O controller on the data-memory bus.
//   clk, reset_n : system clock, asynchronous active-low reset
//   bus          : slave side of the data bus (addr, wr_en, rd_en, wr_data
//                  in; rd_data, io_hit out, both combinational)
//   key_raw      : board keys, 0 = pressed
//   sw_raw       : board switches
//   ledr         : red LED drive (registered)
//   hex_digits   : hex digit nibbles, digit 0 in the LSBs (registered)
//   intr         : registered interrupt request
// KEY and SW are debounced; each group has a sticky READY (set on any
// debounced change, cleared by a load of the data register), a sticky
// OVERRUN (change while READY is still pending) and an interrupt enable.
module mmio_io_ctrl
    import mmio_io_ctrl_pkg::*;
#(
    parameter int               DBITS           = 32,
    parameter int               N_KEYS          = 4,
    parameter int               N_SW            = 10,
    parameter int               N_LEDR          = 10,
    parameter int               N_HEX           = 4,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter logic [DBITS-1:0] ADDR_HEX        = DBITS'(ADDR_HEX_DEF),
    parameter logic [DBITS-1:0] ADDR_LEDR       = DBITS'(ADDR_LEDR_DEF),
    parameter logic [DBITS-1:0] ADDR_KEY        = DBITS'(ADDR_KEY_DEF),
    parameter logic [DBITS-1:0] ADDR_SW         = DBITS'(ADDR_SW_DEF),
    parameter logic [DBITS-1:0] ADDR_KCTRL      = DBITS'(ADDR_KCTRL_DEF),
    parameter logic [DBITS-1:0] ADDR_SCTRL      = DBITS'(ADDR_SCTRL_DEF)
) (
    input  logic               clk,
    input  logic               reset_n,
    mmio_io_ctrl_if.slave      bus,
    input  logic [N_KEYS-1:0]  key_raw,
    input  logic [N_SW-1:0]    sw_raw,
    output logic [N_LEDR-1:0]  ledr,
    output logic [N_HEX*4-1:0] hex_digits,
    output logic               intr
);

    reg_sel_e            sel_s;
    logic [N_KEYS-1:0]   key_deb_s;
    logic [N_SW-1:0]     sw_deb_s;
    logic                key_chg_s;
    logic                sw_chg_s;
    logic                key_rd_s;
    logic                sw_rd_s;
    logic                kctrl_wr_s;
    logic                sctrl_wr_s;

    logic [N_HEX*4-1:0]  hex_r;
    logic [N_LEDR-1:0]   ledr_r;
    logic                k_ready_r;
    logic                k_ovr_r;
    logic                k_ie_r;
    logic                s_ready_r;
    logic                s_ovr_r;
    logic                s_ie_r;
    logic                intr_r;

    // Store data bits above the widest register field are intentionally dropped.
    logic                unused_wr_data_s;
    assign unused_wr_data_s = ^bus.wr_data;

    input_debouncer #(
        .WIDTH           (N_KEYS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_deb (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (~key_raw),
        .dout    (key_deb_s),
        .change  (key_chg_s)
    );

    input_debouncer #(
        .WIDTH           (N_SW),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_deb (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (sw_raw),
        .dout    (sw_deb_s),
        .change  (sw_chg_s)
    );

    // Address decode into a register select.
    always_comb begin
        case (bus.addr)
            ADDR_HEX:   sel_s = SEL_HEX;
            ADDR_LEDR:  sel_s = SEL_LEDR;
            ADDR_KEY:   sel_s = SEL_KEY;
            ADDR_SW:    sel_s = SEL_SW;
            ADDR_KCTRL: sel_s = SEL_KCTRL;
            ADDR_SCTRL: sel_s = SEL_SCTRL;
            default:    sel_s = SEL_NONE;
        endcase
    end

    assign bus.io_hit = (sel_s != SEL_NONE);
    assign key_rd_s   = bus.rd_en && (sel_s == SEL_KEY);
    assign sw_rd_s    = bus.rd_en && (sel_s == SEL_SW);
    assign kctrl_wr_s = bus.wr_en && (sel_s == SEL_KCTRL);
    assign sctrl_wr_s = bus.wr_en && (sel_s == SEL_SCTRL);

    // Combinational read mux; unmapped addresses read as zero.
    always_comb begin
        case (sel_s)
            SEL_HEX:   bus.rd_data = DBITS'(hex_r);
            SEL_LEDR:  bus.rd_data = DBITS'(ledr_r);
            SEL_KEY:   bus.rd_data = DBITS'(key_deb_s);
            SEL_SW:    bus.rd_data = DBITS'(sw_deb_s);
            SEL_KCTRL: bus.rd_data = DBITS'(ctrl_word(k_ready_r, k_ovr_r, k_ie_r));
            SEL_SCTRL: bus.rd_data = DBITS'(ctrl_word(s_ready_r, s_ovr_r, s_ie_r));
            default:   bus.rd_data = {DBITS{1'b0}};
        endcase
    end

    // Output data registers loaded by stores.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex_r  <= {(N_HEX*4){1'b0}};
            ledr_r <= {N_LEDR{1'b0}};
        end else begin
            if (bus.wr_en && (sel_s == SEL_HEX)) begin
                hex_r <= bus.wr_data[N_HEX*4-1:0];
            end
            if (bus.wr_en && (sel_s == SEL_LEDR)) begin
                ledr_r <= bus.wr_data[N_LEDR-1:0];
            end
        end
    end

    // KEY and SW status. A change event beats a same-cycle data read, and
    // OVERRUN only counts a change that finds an unconsumed READY.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_ready_r <= 1'b0;
            k_ovr_r   <= 1'b0;
            k_ie_r    <= 1'b0;
            s_ready_r <= 1'b0;
            s_ovr_r   <= 1'b0;
            s_ie_r    <= 1'b0;
        end else begin
            if (key_chg_s) begin
                k_ready_r <= 1'b1;
            end else if (key_rd_s) begin
                k_ready_r <= 1'b0;
            end
            if (key_chg_s && k_ready_r && !key_rd_s) begin
                k_ovr_r <= 1'b1;
            end else if (kctrl_wr_s && !bus.wr_data[CTRL_OVERRUN_BIT]) begin
                k_ovr_r <= 1'b0;
            end
            if (kctrl_wr_s) begin
                k_ie_r <= bus.wr_data[CTRL_IE_BIT];
            end

            if (sw_chg_s) begin
                s_ready_r <= 1'b1;
            end else if (sw_rd_s) begin
                s_ready_r <= 1'b0;
            end
            if (sw_chg_s && s_ready_r && !sw_rd_s) begin
                s_ovr_r <= 1'b1;
            end else if (sctrl_wr_s && !bus.wr_data[CTRL_OVERRUN_BIT]) begin
                s_ovr_r <= 1'b0;
            end
            if (sctrl_wr_s) begin
                s_ie_r <= bus.wr_data[CTRL_IE_BIT];
            end
        end
    end

    // Interrupt follows the status bits with one cycle of delay.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            intr_r <= 1'b0;
        end else begin
            intr_r <= (k_ready_r & k_ie_r) | (s_ready_r & s_ie_r);
        end
    end

    assign ledr       = ledr_r;
    assign hex_digits = hex_r;
    assign intr       = intr_r;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Self-checking bench for mmio_io_ctrl: expected values are queued when
// stimulus is applied and popped when the corresponding output is observed.
module tb_mmio_io_ctrl;

    localparam logic [31:0] A_HEX   = 32'hF000_0000;
    localparam logic [31:0] A_LEDR  = 32'hF000_0004;
    localparam logic [31:0] A_KEY   = 32'hF000_0010;
    localparam logic [31:0] A_SW    = 32'hF000_0014;
    localparam logic [31:0] A_KCTRL = 32'hF000_0110;
    localparam logic [31:0] A_SCTRL = 32'hF000_0114;
    localparam logic [31:0] A_NONE  = 32'hF000_0020;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  key_raw = 4'hF;
    logic [9:0]  sw_raw  = 10'h000;
    logic [9:0]  ledr;
    logic [15:0] hex_digits;
    logic        intr;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp;
    logic [31:0] d;

    mmio_io_ctrl_if #(.DBITS(32)) bus ();

    mmio_io_ctrl #(
        .DBITS(32), .N_KEYS(4), .N_SW(10), .N_LEDR(10), .N_HEX(4),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .key_raw    (key_raw),
        .sw_raw     (sw_raw),
        .ledr       (ledr),
        .hex_digits (hex_digits),
        .intr       (intr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.addr    = A_NONE;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_data = 32'h0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] v);
        bus.addr  = a;
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        #1;
        v = bus.rd_data;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] v);
        bus.addr    = a;
        bus.wr_data = v;
        bus.wr_en   = 1'b1;
        tick(1);
        bus.wr_en   = 1'b0;
    endtask

    task automatic read_strobe(input logic [31:0] a);
        bus.addr  = a;
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
    endtask

    task automatic do_reset();
        key_raw = 4'hF;
        sw_raw  = 10'h000;
        bus_idle();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        logic [31:0] addrs [6];
        addrs = '{A_HEX, A_LEDR, A_KEY, A_SW, A_KCTRL, A_SCTRL};
        do_reset();
        write(A_HEX, 32'h0000_5A5A);
        write(A_LEDR, 32'h0000_0155);
        write(A_SCTRL, 32'h0000_0100);
        sw_raw[0] = 1'b1;
        exp_q.push_back(32'h1);
        tick(22);
        exp = exp_q.pop_front(); checks++;
        if ({31'h0, intr} !== exp) begin errors++; $display("FAIL pre_reset_intr: got %h required %h", intr, exp); end
        // Assert reset mid-cycle: clearing must not wait for a clock edge.
        #2;
        reset_n = 1'b0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front(); checks++;
        if ({31'h0, intr} !== exp) begin errors++; $display("FAIL reset_intr: got %h required %h", intr, exp); end
        exp = exp_q.pop_front(); checks++;
        if ({22'h0, ledr} !== exp) begin errors++; $display("FAIL reset_ledr: got %h required %h", ledr, exp); end
        exp = exp_q.pop_front(); checks++;
        if ({16'h0, hex_digits} !== exp) begin errors++; $display("FAIL reset_hex: got %h required %h", hex_digits, exp); end
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(32'h0);
            peek(addrs[i], d);
            exp = exp_q.pop_front(); checks++;
            if (d !== exp) begin errors++; $display("FAIL reset_read_%h: got %h required %h", addrs[i], d, exp); end
        end
        sw_raw = 10'h000;
        tick(1);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic test_key_debounce();
        do_reset();
        key_raw[1] = 1'b0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h2);
        tick(17);
        peek(A_KEY, d);
        exp = exp_q.pop_front(); checks++;
        if (d !== exp) begin errors++; $display("FAIL key_at_17: got %h required %h", d, exp); end
        tick(1);
        peek(A_KEY, d);
        exp = exp_q.pop_front(); checks++;
        if (d !== exp) begin errors++; $display("FAIL key_at_18: got %h required %h", d, exp); end

        do_reset();
        key_raw[0] = 1'b0;
        tick(10);
        key_raw[0] = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        tick(30);
        peek(A_KEY, d);
        exp = exp_q.pop_front(); checks++;
        if (d !== exp) begin errors++; $display("FAIL glitch_key: got %h required %h", d, exp); end
        peek(A_KCTRL, d);
        exp = exp_q.pop_front(); checks++;
        if (d !== exp) begin errors++; $display("FAIL glitch_ready: got %h required %h", d, exp); end
    endtask

    task automatic test_ready_overrun();
        do_reset();
        key_raw[0] = 1'b0;
        exp_q.push_back(32'h1);
        tick(18);
        peek(A_KCTRL, d);
        exp = exp_q.pop_front(); checks++;
        if (d !== exp) begin errors++; $display("FAIL kctrl_ready: got %h required %h", d, exp); end
        key_raw[2] = 1'b0;
        exp_q.push_back(32'h5);
        exp_q.push_back(32'h5);
        tick(18);
        peek(A_KCTRL, d);
        exp = exp_q.pop_front(); checks++;
        if (d !== exp) begin errors++; $display("FAIL kctrl_overrun: got %h required %h", d, exp); end
        peek(A_KEY, d);
        exp = exp_q.pop_front(); checks++;
        if (d !== exp) begin errors++; $display("FAIL key_two_pressed: got %h required %h", d, exp); end
        read_strobe(A_KEY);
        exp_q.push_back(32'h4);
        peek(A_KCTRL, d);
        exp = exp_q.pop_front(); checks++;
        if (d !== exp) begin errors++; $display("FAIL kctrl_after_read: got %h required %h", d, exp); end
        write(A_KCTRL, 32'h0000_0004);
        exp_q.push_back(32'h4);
        peek(A_KCTRL, d);
        exp = exp_q.pop_front(); checks++;
        if (d !== exp) begin errors++; $display("FAIL kctrl_write1_keeps: got %h required %h", d, exp); end
        write(A_KCTRL, 32'h0000_0000);
        exp_q.push_back(32'h0);
        peek(A_KCTRL, d);
        exp = exp_q.pop_front(); checks++;
        if (d !== exp) begin errors++; $display("FAIL kctrl_write0_clears: got %h required %h", d, exp); end
    endtask

    task automatic test_interrupt();
        do_reset();
        write(A_SCTRL, 32'h0000_0100);
        exp_q.push_back(32'h100);
        peek(A_SCTRL, d);
        exp = exp_q.pop_front(); checks++;
        if (d !== exp) begin errors++; $display("FAIL sctrl_ie: got %h required %h", d, exp); end
        sw_raw[9] = 1'b1;
        exp_q.push_back(32'h101);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        tick(18);
        peek(A_SCTRL, d);
        exp = exp_q.pop_front(); checks++;
        if (d !== exp) begin errors++; $display("FAIL sctrl_ready: got %h required %h", d, exp); end
        exp = exp_q.pop_front(); checks++;
        if ({31'h0, intr} !== exp) begin errors++; $display("FAIL intr_same_cycle: got %h required %h", intr, exp); end
        tick(1);
        exp = exp_q.pop_front(); checks++;
        if ({31'h0, intr} !== exp) begin errors++; $display("FAIL intr_rise: got %h required %h", intr, exp); end
        exp_q.push_back(32'h200);
        peek(A_SW, d);
        exp = exp_q.pop_front(); checks++;
        if (d !== exp) begin errors++; $display("FAIL sw_value: got %h required %h", d, exp); end
        read_strobe(A_SW);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if ({31'h0, intr} !== exp) begin errors++; $display("FAIL intr_hold: got %h required %h", intr, exp); end
        peek(A_SCTRL, d);
        exp = exp_q.pop_front(); checks++;
        if (d !== exp) begin errors++; $display("FAIL sctrl_cleared: got %h required %h", d, exp); end
        tick(1);
        exp = exp_q.pop_front(); checks++;
        if ({31'h0, intr} !== exp) begin errors++; $display("FAIL intr_drop: got %h required %h", intr, exp); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        key_raw[0] = 1'b0;
        tick(18);
        key_raw[3] = 1'b0;
        tick(17);
        // The read lands on the same edge as the key3 debounced change.
        bus.addr  = A_KEY;
        bus.rd_en = 1'b1;
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h9);
        tick(1);
        bus.rd_en = 1'b0;
        peek(A_KCTRL, d);
        exp = exp_q.pop_front(); checks++;
        if (d !== exp) begin errors++; $display("FAIL simul_kctrl: got %h required %h", d, exp); end
        peek(A_KEY, d);
        exp = exp_q.pop_front(); checks++;
        if (d !== exp) begin errors++; $display("FAIL simul_key: got %h required %h", d, exp); end
        read_strobe(A_KEY);
        exp_q.push_back(32'h0);
        peek(A_KCTRL, d);
        exp = exp_q.pop_front(); checks++;
        if (d !== exp) begin errors++; $display("FAIL simul_then_read: got %h required %h", d, exp); end
    endtask

    task automatic test_output_regs();
        do_reset();
        write(A_HEX, 32'hABCD_1234);
        exp_q.push_back(32'h1234);
        exp_q.push_back(32'h1234);
        exp = exp_q.pop_front(); checks++;
        if ({16'h0, hex_digits} !== exp) begin errors++; $display("FAIL hex_port: got %h required %h", hex_digits, exp); end
        peek(A_HEX, d);
        exp = exp_q.pop_front(); checks++;
        if (d !== exp) begin errors++; $display("FAIL hex_read: got %h required %h", d, exp); end
        write(A_LEDR, 32'hFFFF_FFFF);
        exp_q.push_back(32'h3FF);
        exp_q.push_back(32'h3FF);
        exp = exp_q.pop_front(); checks++;
        if ({22'h0, ledr} !== exp) begin errors++; $display("FAIL ledr_port: got %h required %h", ledr, exp); end
        peek(A_LEDR, d);
        exp = exp_q.pop_front(); checks++;
        if (d !== exp) begin errors++; $display("FAIL ledr_read: got %h required %h", d, exp); end
        write(A_KEY, 32'hFFFF_FFFF);
        exp_q.push_back(32'h0);
        peek(A_KEY, d);
        exp = exp_q.pop_front(); checks++;
        if (d !== exp) begin errors++; $display("FAIL key_write_ignored: got %h required %h", d, exp); end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        peek(A_NONE, d);
        exp = exp_q.pop_front(); checks++;
        if ({31'h0, bus.io_hit} !== exp) begin errors++; $display("FAIL unmapped_hit: got %h required %h", bus.io_hit, exp); end
        exp = exp_q.pop_front(); checks++;
        if (d !== exp) begin errors++; $display("FAIL unmapped_data: got %h required %h", d, exp); end
        peek(A_SCTRL, d);
        exp = exp_q.pop_front(); checks++;
        if ({31'h0, bus.io_hit} !== exp) begin errors++; $display("FAIL mapped_hit: got %h required %h", bus.io_hit, exp); end
    endtask

    initial begin
        bus_idle();
        test_reset();
        test_key_debounce();
        test_ready_overrun();
        test_interrupt();
        test_simultaneous();
        test_output_regs();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries required 0", exp_q.size());
        end
        checks++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
